// File: rtl/mips_fetch_pkg.sv
// Shared constants, entry type and counter-width helpers for the MIPS32 fetch unit.
package mips_fetch_pkg;

  localparam int unsigned DEF_ADDR_W          = 32;
  localparam int unsigned DEF_INST_W          = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam int unsigned DEF_FIFO_DEPTH      = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_FIFO_CNT_W = cnt_w(DEF_FIFO_DEPTH);
  localparam int unsigned DEF_OUT_CNT_W  = cnt_w(DEF_MAX_OUTSTANDING);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch unit bus: memory request/response, decode handshake, redirect/halt control, status.
interface mips_fetch_if import mips_fetch_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned INST_W = DEF_INST_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] inst_pc;
  logic [INST_W-1:0] inst_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              err;
  logic [63:0]       fetch_count;

  modport master (
    output req_valid, req_addr, inst_valid, inst_pc, inst_data, err, fetch_count,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst_pc, inst_data, err, fetch_count,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/mips_fetch_fifo.sv
// Generic synchronous FIFO; clear has priority, push into full is allowed when popping.
module mips_fetch_fifo import mips_fetch_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS32 instruction-fetch front end: credit-limited request issue, in-order response
// pairing via a PC tag queue, prefetch FIFO to decode, redirect flush with stale-drop.
module mips_fetch_unit import mips_fetch_pkg::*; #(
  parameter int unsigned       ADDR_W          = DEF_ADDR_W,
  parameter int unsigned       INST_W          = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned       MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic         clk,
  input  logic         rst,
  mips_fetch_if.master bus
);
  localparam int unsigned FCNT_W  = cnt_w(FIFO_DEPTH);
  localparam int unsigned OCNT_W  = cnt_w(MAX_OUTSTANDING);
  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc;
  logic [OCNT_W-1:0]  outstanding, drop;
  logic               err_q;
  logic [63:0]        fetch_count_q;

  logic [FCNT_W-1:0]  pf_count;
  logic               pf_empty, pf_full, pf_push, pf_pop;
  logic [ENTRY_W-1:0] pf_head;
  logic [ADDR_W-1:0]  tag_pc;
  logic [OCNT_W-1:0]  tq_count;
  logic               tq_full, tq_empty;
  logic               credit, issue;
  logic [31:0]        occupancy;

  // Every issued request must have a guaranteed FIFO slot once stale ones are discounted.
  always_comb begin
    occupancy = 32'(pf_count) + 32'(outstanding) - 32'(drop);
    credit    = (32'(outstanding) < MAX_OUTSTANDING) && (occupancy < FIFO_DEPTH);
  end

  assign bus.req_valid   = !rst && !bus.halt && !err_q && !bus.redirect_valid && credit;
  assign bus.req_addr    = pc;
  assign issue           = bus.req_valid && bus.req_ready;
  assign bus.err         = err_q;
  assign bus.fetch_count = fetch_count_q;

  assign pf_push = bus.resp_valid && (drop == '0) && !bus.redirect_valid && !err_q;
  assign pf_pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  assign bus.inst_valid                = !rst && !pf_empty;
  assign {bus.inst_pc, bus.inst_data}  = pf_head;

  mips_fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (issue),
    .pop   (bus.resp_valid),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tq_full),
    .empty (tq_empty),
    .count (tq_count)
  );

  mips_fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect_valid),
    .push  (pf_push),
    .pop   (pf_pop),
    .din   ({tag_pc, bus.resp_data}),
    .dout  (pf_head),
    .full  (pf_full),
    .empty (pf_empty),
    .count (pf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      outstanding   <= '0;
      drop          <= '0;
      err_q         <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc   <= bus.redirect_pc;
        drop <= outstanding - OCNT_W'(bus.resp_valid);
        if (bus.redirect_pc[1:0] != 2'b00) err_q <= 1'b1;
      end else begin
        if (issue) pc <= pc + ADDR_W'(4);
        if (bus.resp_valid && (drop != '0)) drop <= drop - OCNT_W'(1);
      end
      outstanding <= outstanding + OCNT_W'(issue) - OCNT_W'(bus.resp_valid);
      if (issue) fetch_count_q <= fetch_count_q + 64'(1);
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, pf_full, tq_full, tq_empty, tq_count};

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a fixed-latency in-order memory model.
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat    = 1;
  int   edge_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t pop_q[$];

  mips_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  mips_fetch_unit #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(32'hBFC0_0000),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] popped_pc(input int i);
    if (i < pop_q.size()) return pop_q[i].pc;
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, then drive the memory response after posedge.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (bus.req_valid && bus.req_ready)
        mq.push_back('{bus.req_addr, edge_cnt + 1 + lat});
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        e.pc   = bus.inst_pc;
        e.inst = bus.inst_data;
        pop_q.push_back(e);
        chk("inst_data", 64'(bus.inst_data), 64'(mem_word(bus.inst_pc)));
      end
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (mq.size() > 0 && mq[0].due == edge_cnt + 1) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pop_q.delete();
    #1;
  endtask

  initial begin
    int stale;
    rst                = 1'b1;
    bus.req_ready      = 1'b1;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'(0));

    // Sequential fetch, latency 1, decode always ready
    lat = 1;
    do_reset();
    chk("s1_err", 64'(bus.err), 64'(0));
    chk("s1_count0", bus.fetch_count, 64'(0));
    chk("s1_req_valid", 64'(bus.req_valid), 64'(1));
    chk("s1_addr0", 64'(bus.req_addr), 64'h0000_0000_BFC0_0000);
    tick();
    chk("s1_addr1", 64'(bus.req_addr), 64'h0000_0000_BFC0_0004);
    chk("s1_count1", bus.fetch_count, 64'(1));
    chk("s1_inst_valid_a", 64'(bus.inst_valid), 64'(0));
    tick();
    chk("s1_addr2", 64'(bus.req_addr), 64'h0000_0000_BFC0_0008);
    chk("s1_inst_valid_b", 64'(bus.inst_valid), 64'(1));
    chk("s1_inst_pc0", 64'(bus.inst_pc), 64'h0000_0000_BFC0_0000);
    chk("s1_inst_data0", 64'(bus.inst_data), 64'(mem_word(32'hBFC0_0000)));
    tick();
    chk("s1_count3", bus.fetch_count, 64'(3));
    chk("s1_inst_pc1", 64'(bus.inst_pc), 64'h0000_0000_BFC0_0004);

    // Decode stalled: FIFO fills to 4 and issue stops
    bus.inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    chk("s2_req_valid", 64'(bus.req_valid), 64'(0));
    chk("s2_inst_valid", 64'(bus.inst_valid), 64'(1));
    chk("s2_head_pc", 64'(bus.inst_pc), 64'h0000_0000_BFC0_0000);
    chk("s2_count4", bus.fetch_count, 64'(4));
    tick();
    tick();
    chk("s2_count_hold", bus.fetch_count, 64'(4));
    chk("s2_inst_valid_hold", 64'(bus.inst_valid), 64'(1));
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("s2_pop0", 64'(popped_pc(0)), 64'h0000_0000_BFC0_0000);
    chk("s2_pop1", 64'(popped_pc(1)), 64'h0000_0000_BFC0_0004);
    chk("s2_pop2", 64'(popped_pc(2)), 64'h0000_0000_BFC0_0008);
    chk("s2_pop3", 64'(popped_pc(3)), 64'h0000_0000_BFC0_000C);
    chk("s2_pop4", 64'(popped_pc(4)), 64'h0000_0000_BFC0_0010);

    // Latency 3, redirect with two requests in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0000;
    #1;
    chk("s3_req_valid_redir", 64'(bus.req_valid), 64'(0));
    tick();
    bus.redirect_valid = 1'b0;
    pop_q.delete();
    #1;
    chk("s3_inst_valid_after", 64'(bus.inst_valid), 64'(0));
    chk("s3_addr", 64'(bus.req_addr), 64'h0000_0000_0040_0000);
    chk("s3_req_valid_full", 64'(bus.req_valid), 64'(0));
    for (int i = 0; i < 8; i++) tick();
    chk("s3_npops", 64'(pop_q.size() >= 2), 64'(1));
    chk("s3_pop0", 64'(popped_pc(0)), 64'h0000_0000_0040_0000);
    chk("s3_pop1", 64'(popped_pc(1)), 64'h0000_0000_0040_0004);
    stale = 0;
    foreach (pop_q[i]) if (pop_q[i].pc[31:24] == 8'hBF) stale++;
    chk("s3_stale", 64'(stale), 64'(0));

    // Redirect coinciding with a response and a decode pop
    lat = 1;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    #1;
    chk("s4_pre_inst_valid", 64'(bus.inst_valid), 64'(1));
    chk("s4_pre_resp", 64'(bus.resp_valid), 64'(1));
    tick();
    bus.redirect_valid = 1'b0;
    pop_q.delete();
    #1;
    chk("s4_inst_valid", 64'(bus.inst_valid), 64'(0));
    chk("s4_addr", 64'(bus.req_addr), 64'h0000_0000_0000_1000);
    chk("s4_req_valid", 64'(bus.req_valid), 64'(1));
    for (int i = 0; i < 3; i++) tick();
    chk("s4_pop0", 64'(popped_pc(0)), 64'h0000_0000_0000_1000);

    // Misaligned redirect target sets sticky err
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0002;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("s5_err", 64'(bus.err), 64'(1));
    chk("s5_req_valid", 64'(bus.req_valid), 64'(0));
    chk("s5_pc_loaded", 64'(bus.req_addr), 64'h0000_0000_0040_0002);
    for (int i = 0; i < 3; i++) tick();
    chk("s5_err_sticky", 64'(bus.err), 64'(1));
    chk("s5_req_valid_hold", 64'(bus.req_valid), 64'(0));
    chk("s5_count", bus.fetch_count, 64'(3));
    do_reset();
    chk("s5_err_clr", 64'(bus.err), 64'(0));
    chk("s5_addr_rst", 64'(bus.req_addr), 64'h0000_0000_BFC0_0000);
    chk("s5_count_rst", bus.fetch_count, 64'(0));

    // Halt with one request outstanding
    lat = 3;
    do_reset();
    tick();
    bus.halt = 1'b1;
    #1;
    chk("s6_req_valid_halt", 64'(bus.req_valid), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_req_valid_loop", 64'(bus.req_valid), 64'(0));
    end
    chk("s6_npops", 64'(pop_q.size()), 64'(1));
    chk("s6_pop0", 64'(popped_pc(0)), 64'h0000_0000_BFC0_0000);
    chk("s6_count", bus.fetch_count, 64'(1));
    bus.halt = 1'b0;
    #1;
    chk("s6_resume_valid", 64'(bus.req_valid), 64'(1));
    chk("s6_resume_addr", 64'(bus.req_addr), 64'h0000_0000_BFC0_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
